// File: rtl/secuenciador_etapas_pkg.sv
// Shared definitions for the stage sequencer: FSM encoding and stage limits.
package secuenciador_etapas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } fsm_estado_e;

  localparam int         NUM_ETAPAS   = 6;
  localparam logic [2:0] ULTIMA_ETAPA = 3'(NUM_ETAPAS - 1);

endpackage

// File: rtl/secuenciador_etapas_detector_flanco.sv
// Registered rising-edge detector: one pulse per low-to-high transition.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic senal_i,
  output logic flanco_o
);

  logic previo_q;
  logic flanco_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      previo_q <= 1'b0;
      flanco_q <= 1'b0;
    end else begin
      previo_q <= senal_i;
      flanco_q <= senal_i & ~previo_q;
    end
  end

  assign flanco_o = flanco_q;

endmodule

// File: rtl/secuenciador_etapas.sv
// Credit-gated sequencer stepping estado through stages 0..5 for ControlEstado,
// with coin counting, pause and cancel.
module secuenciador_etapas #(
  parameter int PRECIO   = 2,
  parameter int CRED_W   = 4,
  parameter int CRED_MAX = 15,
  parameter int DUR_W    = 8,
  parameter int DUR      = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              moneda,
  input  logic              inicio,
  input  logic              pausa,
  input  logic              cancelar,
  output logic [2:0]        estado,
  output logic              avance,
  output logic              credito,
  output logic [CRED_W-1:0] creditos,
  output logic              ocupado,
  output logic              fin
);

  import secuenciador_etapas_pkg::*;

  localparam logic [DUR_W-1:0] TIMER_FIN  = DUR_W'(DUR - 1);
  localparam logic [CRED_W:0]  PRECIO_EXT = (CRED_W + 1)'(PRECIO);
  localparam logic [CRED_W:0]  MAX_EXT    = (CRED_W + 1)'(CRED_MAX);

  logic moneda_ev;
  logic inicio_ev;

  detector_flanco u_flanco_moneda (
    .clk      (clk),
    .rst      (rst),
    .senal_i  (moneda),
    .flanco_o (moneda_ev)
  );

  detector_flanco u_flanco_inicio (
    .clk      (clk),
    .rst      (rst),
    .senal_i  (inicio),
    .flanco_o (inicio_ev)
  );

  fsm_estado_e       fsm_q, fsm_d;
  logic [2:0]        etapa_q, etapa_d;
  logic [DUR_W-1:0]  timer_q, timer_d;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic              avance_q, avance_d;
  logic              credito_q, credito_d;
  logic              ocupado_q, ocupado_d;
  logic              fin_q, fin_d;

  logic [CRED_W:0]   disponible;
  logic              arranque;

  // A coin arriving in the same cycle as a start request counts toward the price.
  always_comb begin
    disponible = {1'b0, cred_q} + {{CRED_W{1'b0}}, moneda_ev};
    if (disponible > MAX_EXT) begin
      disponible = MAX_EXT;
    end
    arranque = (fsm_q == IDLE) && inicio_ev && (disponible >= PRECIO_EXT);
    if (arranque) begin
      cred_d = CRED_W'(disponible - PRECIO_EXT);
    end else begin
      cred_d = disponible[CRED_W-1:0];
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    etapa_d = etapa_q;
    timer_d = timer_q;

    unique case (fsm_q)
      IDLE: begin
        etapa_d = 3'd0;
        timer_d = '0;
        if (arranque) begin
          fsm_d = RUN;
        end
      end

      RUN: begin
        if (cancelar) begin
          fsm_d   = IDLE;
          etapa_d = 3'd0;
          timer_d = '0;
        end else if (pausa) begin
          fsm_d = PAUSE;
        end else if (timer_q == TIMER_FIN) begin
          timer_d = '0;
          if (etapa_q == ULTIMA_ETAPA) begin
            fsm_d   = DONE;
            etapa_d = 3'd0;
          end else begin
            etapa_d = etapa_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + DUR_W'(1);
        end
      end

      PAUSE: begin
        if (cancelar) begin
          fsm_d   = IDLE;
          etapa_d = 3'd0;
          timer_d = '0;
        end else if (!pausa) begin
          fsm_d = RUN;
        end
      end

      DONE: begin
        fsm_d   = IDLE;
        etapa_d = 3'd0;
        timer_d = '0;
      end

      default: begin
        fsm_d   = IDLE;
        etapa_d = 3'd0;
        timer_d = '0;
      end
    endcase

    avance_d  = (fsm_d == RUN);
    credito_d = (fsm_d == RUN) || (fsm_d == PAUSE);
    ocupado_d = (fsm_d == RUN) || (fsm_d == PAUSE);
    fin_d     = (fsm_d == DONE);
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      etapa_q   <= 3'd0;
      timer_q   <= '0;
      cred_q    <= '0;
      avance_q  <= 1'b0;
      credito_q <= 1'b0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      etapa_q   <= etapa_d;
      timer_q   <= timer_d;
      cred_q    <= cred_d;
      avance_q  <= avance_d;
      credito_q <= credito_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign estado   = etapa_q;
  assign avance   = avance_q;
  assign credito  = credito_q;
  assign creditos = cred_q;
  assign ocupado  = ocupado_q;
  assign fin      = fin_q;

endmodule

// File: tb/tb_secuenciador_etapas.sv
// Scoreboard bench for secuenciador_etapas with DUR=4 and PRECIO=2.
module tb_secuenciador_etapas;

  logic       clk = 1'b0;
  logic       rst;
  logic       moneda;
  logic       inicio;
  logic       pausa;
  logic       cancelar;
  logic [2:0] estado;
  logic       avance;
  logic       credito;
  logic [3:0] creditos;
  logic       ocupado;
  logic       fin;

  secuenciador_etapas #(
    .PRECIO   (2),
    .CRED_W   (4),
    .CRED_MAX (15),
    .DUR_W    (8),
    .DUR      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .moneda   (moneda),
    .inicio   (inicio),
    .pausa    (pausa),
    .cancelar (cancelar),
    .estado   (estado),
    .avance   (avance),
    .credito  (credito),
    .creditos (creditos),
    .ocupado  (ocupado),
    .fin      (fin)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] val;
  } exp_t;

  exp_t  expQ[$];
  int    finQ[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    endReq = 1'b0;
  bit    endDone = 1'b0;
  logic [10:0] act;
  exp_t  cur;
  int    finExp;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares queued snapshots and every fin pulse against the scoreboard.
  always @(negedge clk) begin
    act = {estado, avance, credito, ocupado, fin, creditos};
    while (expQ.size() > 0) begin
      cur = expQ.pop_front();
      checks++;
      if (act !== cur.val) begin
        errors++;
        $display("[TB] FAIL %s: got estado=%0d avance=%b credito=%b ocupado=%b fin=%b creditos=%0d; expected estado=%0d avance=%b credito=%b ocupado=%b fin=%b creditos=%0d",
                 cur.name, act[10:8], act[7], act[6], act[5], act[4], act[3:0],
                 cur.val[10:8], cur.val[7], cur.val[6], cur.val[5], cur.val[4], cur.val[3:0]);
      end
    end
    if (fin === 1'b1) begin
      checks++;
      if (finQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL fin_unexpected: fin high at cycle %0d, expected no pulse", cyc);
      end else begin
        finExp = finQ.pop_front();
        if (finExp != cyc) begin
          errors++;
          $display("[TB] FAIL fin_timing: fin at cycle %0d, expected cycle %0d", cyc, finExp);
        end
      end
    end
    if (endReq && !endDone) begin
      checks++;
      if (finQ.size() != 0) begin
        errors++;
        $display("[TB] FAIL fin_missing: %0d pending fin pulses, expected 0", finQ.size());
      end
      endDone = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] es, input logic av,
                             input logic cr, input logic oc, input logic fi,
                             input logic [3:0] cs);
    exp_t e;
    e.name = name;
    e.val  = {es, av, cr, oc, fi, cs};
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic m, input logic i, input int hold, input int idle);
    moneda = m;
    inicio = i;
    step(hold);
    moneda = 1'b0;
    inicio = 1'b0;
    step(idle);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; moneda = 1'b0; inicio = 1'b0; pausa = 1'b0; cancelar = 1'b0;
    step(2);
    checkOutput("reset", 3'd0, 0, 0, 0, 0, 4'd0);
    rst = 1'b0;

    // Three coins, then a paid start
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1, 1);
    checkOutput("coins3", 3'd0, 0, 0, 0, 0, 4'd3);
    applyStimulus(1'b0, 1'b1, 1, 1);
    checkOutput("start", 3'd0, 1, 1, 1, 0, 4'd1);
    finQ.push_back(cyc + 24);
    for (int s = 1; s < 6; s++) begin
      step(4);
      checkOutput($sformatf("stage%0d", s), 3'(s), 1, 1, 1, 0, 4'd1);
    end
    step(4);
    checkOutput("done", 3'd0, 0, 0, 0, 1, 4'd1);
    step(1);
    checkOutput("idle_after_done", 3'd0, 0, 0, 0, 0, 4'd1);

    // Insufficient credit, then coin in the same cycle as inicio
    applyStimulus(1'b0, 1'b1, 1, 1);
    checkOutput("no_start_1credit", 3'd0, 0, 0, 0, 0, 4'd1);
    applyStimulus(1'b1, 1'b1, 1, 1);
    checkOutput("start_with_coin", 3'd0, 1, 1, 1, 0, 4'd0);

    // Pause in stage 2 after one timer cycle
    step(8);
    checkOutput("pre_pause_stage2", 3'd2, 1, 1, 1, 0, 4'd0);
    step(1);
    pausa = 1'b1;
    step(1);
    checkOutput("pause_enter", 3'd2, 0, 1, 1, 0, 4'd0);
    step(5);
    checkOutput("pause_mid", 3'd2, 0, 1, 1, 0, 4'd0);
    step(4);
    checkOutput("pause_last", 3'd2, 0, 1, 1, 0, 4'd0);
    pausa = 1'b0;
    step(1);
    checkOutput("resume", 3'd2, 1, 1, 1, 0, 4'd0);
    step(2);
    checkOutput("stage2_tail", 3'd2, 1, 1, 1, 0, 4'd0);
    step(1);
    checkOutput("stage3_entry", 3'd3, 1, 1, 1, 0, 4'd0);

    // Cancel together with pause in stage 3
    step(1);
    cancelar = 1'b1;
    pausa = 1'b1;
    step(1);
    checkOutput("cancel", 3'd0, 0, 0, 0, 0, 4'd0);
    cancelar = 1'b0;
    pausa = 1'b0;
    step(30);
    checkOutput("cancel_stays_idle", 3'd0, 0, 0, 0, 0, 4'd0);

    // Saturation at 15
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1, 1);
      if (i == 13) checkOutput("coins14", 3'd0, 0, 0, 0, 0, 4'd14);
    end
    checkOutput("coins_saturated", 3'd0, 0, 0, 0, 0, 4'd15);

    // Start, ignored inicio during RUN, reset mid-stage 4
    applyStimulus(1'b0, 1'b1, 1, 1);
    checkOutput("start_from15", 3'd0, 1, 1, 1, 0, 4'd13);
    applyStimulus(1'b0, 1'b1, 1, 1);
    checkOutput("inicio_in_run_ignored", 3'd0, 1, 1, 1, 0, 4'd13);
    step(16);
    checkOutput("mid_stage4", 3'd4, 1, 1, 1, 0, 4'd13);
    rst = 1'b1;
    step(1);
    checkOutput("reset_mid_run", 3'd0, 0, 0, 0, 0, 4'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1, 1);
    checkOutput("no_start_0credit", 3'd0, 0, 0, 0, 0, 4'd0);
    step(10);
    checkOutput("idle_after_reset", 3'd0, 0, 0, 0, 0, 4'd0);
    applyStimulus(1'b1, 1'b0, 5, 2);
    checkOutput("held_coin_once", 3'd0, 0, 0, 0, 0, 4'd1);

    step(1);
    endReq = 1'b1;
    for (int k = 0; k < 10 && !endDone; k++) @(posedge clk);
    if (!endDone) begin
      $display("[TB] FAIL monitor_end: monitor did not finish, expected completion");
      $fatal(1, "[TB] monitor stalled");
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/secuenciador_etapas.md
Name: secuenciador_etapas

Overview:
Credit-gated sequencer that drives the `estado`/`avance`/`credito` inputs of ControlEstado.
- Counts coin pulses into a credit register.
- Charges PRECIO credits per cycle started.
- Steps `estado` through stages 0..5, holding each stage for DUR clock cycles, with pause and cancel support.
- Sits between the user-input synchronisers and ControlEstado, whose `estado_actual` becomes estado+1 while running and 0 otherwise.

Parameters:
- PRECIO, 2, credits consumed per started cycle (1..CRED_MAX).
- CRED_W, 4, width of credit counter.
- CRED_MAX, 15, saturation value of credit counter (≤ 2^CRED_W-1).
- DUR_W, 8, width of stage timer.
- DUR, 100, clock cycles per stage (2..2^DUR_W-1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- moneda  in  1  coin input, already synchronised; each rising edge = +1 credit.
- inicio  in  1  start request, already synchronised; rising edge sampled.
- pausa  in  1  level; high freezes the running stage.
- cancelar  in  1  level/pulse; aborts the cycle, no refund.
- estado  out  3  current stage 0..5 (to ControlEstado.estado).
- avance  out  1  high while in RUN (to ControlEstado.avance).
- credito  out  1  high while a paid cycle is in RUN or PAUSE (to ControlEstado.credito).
- creditos  out  CRED_W  current credit balance.
- ocupado  out  1  high in RUN or PAUSE.
- fin  out  1  one-cycle pulse on normal completion of stage 5.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - FSM=IDLE; estado=0; avance=0; credito=0; creditos=0; ocupado=0; fin=0.
  - Timer=0; edge-detector history registers=0.
  - Reset mid-cycle abandons the cycle and clears credits.
- Edge detection: rising edge = input high now and low in the previous cycle. Holding `moneda` or `inicio` high yields one event.
- Coin event: creditos+1, saturating at CRED_MAX, in every FSM state.
- FSM states:
  - IDLE:
    - Outputs avance=0, credito=0, estado=0.
    - On an `inicio` edge with available ≥ PRECIO, where available = creditos plus a same-cycle coin: subtract PRECIO, go to RUN next cycle with estado=0 and timer=0.
    - Insufficient credit: request ignored, no state change.
    - `cancelar` has no effect in IDLE.
  - RUN:
    - Outputs avance=1, credito=1, ocupado=1.
    - Timer increments each cycle.
    - When timer==DUR-1:
      - estado<5: estado+1, timer=0.
      - estado==5: go to DONE.
  - PAUSE:
    - Outputs avance=0, credito=1, ocupado=1; timer and estado frozen.
    - pausa=0 returns to RUN and resumes at the frozen timer value.
  - DONE (1 cycle):
    - fin=1, avance=0, credito=0, estado=0, ocupado=0.
    - Next state IDLE.
- Priority in RUN/PAUSE: cancelar > pausa > timer expiry.
  - cancelar → IDLE next cycle, credit not refunded, fin stays 0.
  - pausa in RUN → PAUSE next cycle; the timer does not advance in that cycle.
- Latency:
  - An `inicio` edge sampled at edge N gives avance=1, estado=0 after edge N+1.
  - Each stage is exactly DUR cycles in RUN; pause cycles are excluded.
  - fin pulses in the cycle after stage 5's last cycle. Total unpaused run = 6·DUR cycles.
- `inicio` edges during RUN/PAUSE/DONE are ignored; no credit is consumed.
- estado never takes values 6 or 7; all outputs are registered.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN, PAUSE, DONE as 2-bit constants), NUM_ETAPAS=6, ULTIMA_ETAPA=3'd5.
- Sub-module: detector_flanco (1-bit synchronous rising-edge detector with sync reset), instantiated for `moneda` and `inicio`.

Test Plan:
All scenarios use DUR=4, PRECIO=2.
- Reset, then 3 `moneda` pulses → creditos=3; `inicio` pulse → creditos=1, next cycle avance=1, credito=1, estado=0.
- Full run, no pause → estado steps 0,1,2,3,4,5 every 4 cycles; fin=1 for exactly 1 cycle 24 cycles after RUN entry; then avance=credito=ocupado=0, estado=0.
- creditos=1, `inicio` pulse → no start, creditos stays 1. Same test with a coin edge in the same cycle as `inicio` → start, creditos=0.
- During stage 2, after 1 timer cycle, pausa high for 10 cycles → avance=0, credito=1, estado held at 2. After release, stage 2 lasts 3 more cycles.
- During stage 3, assert cancelar together with pausa → IDLE next cycle, fin never asserts, credits not refunded. 20 coin edges → creditos saturates at 15.
- rst asserted mid-stage 4 → after the next edge all outputs 0, creditos=0. A subsequent `inicio` with 0 credits → no start.
